// File: rtl/wb_burst_ram_if.sv
// Wishbone B3 bus bundle between an interconnect master port and the burst RAM slave.
interface wb_burst_ram_if;
   logic [31:0] wb_adr_i;
   logic [31:0] wb_dat_i;
   logic [3:0]  wb_sel_i;
   logic        wb_we_i;
   logic        wb_cyc_i;
   logic        wb_stb_i;
   logic [2:0]  wb_cti_i;
   logic [1:0]  wb_bte_i;
   logic [31:0] wb_dat_o;
   logic        wb_ack_o;
   logic        wb_err_o;
   logic        wb_rty_o;

   modport master (
      output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i, wb_cti_i, wb_bte_i,
      input  wb_dat_o, wb_ack_o, wb_err_o, wb_rty_o
   );

   modport slave (
      input  wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i, wb_cti_i, wb_bte_i,
      output wb_dat_o, wb_ack_o, wb_err_o, wb_rty_o
   );
endinterface

// File: rtl/wb_burst_ram.sv
// Wishbone B3 RAM slave: classic cycles, constant/incrementing (linear or wrap-4/8/16)
// bursts, byte-lane writes and WAIT_STATES extra cycles before the first ack of an access.
module wb_burst_ram #(
   parameter int MEM_DEPTH   = 1024,
   parameter int WAIT_STATES = 0
) (
   input  logic          wb_clk_i,
   input  logic          wb_rst_i,
   wb_burst_ram_if.slave wb
);
   localparam int AW = $clog2(MEM_DEPTH);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT,
      S_CLASSIC,
      S_BURST,
      S_ERR
   } state_t;

   state_t        state_q, state_d;
   logic [AW-1:0] ptr_q, ptr_d;
   logic [AW-1:0] ptr_next, ptr_inc, wrap_mask;
   logic [2:0]    cnt_q, cnt_d;
   logic [2:0]    cti_q, cti_d;
   logic [1:0]    bte_q, bte_d;
   logic [31:0]   dat_q, dat_d;
   logic          ack_q, ack_d;
   logic          err_q, err_d;
   logic          mem_we;
   logic          req;
   logic          cti_reserved;
   logic          start_burst;
   logic          latched_burst;
   logic          unused_adr;
   logic [31:0]   mem [MEM_DEPTH];

   assign req           = wb.wb_cyc_i & wb.wb_stb_i;
   assign cti_reserved  = (wb.wb_cti_i != 3'b000) && (wb.wb_cti_i != 3'b001) &&
                          (wb.wb_cti_i != 3'b010) && (wb.wb_cti_i != 3'b111);
   assign start_burst   = (wb.wb_cti_i == 3'b001) || (wb.wb_cti_i == 3'b010);
   assign latched_burst = (cti_q == 3'b001) || (cti_q == 3'b010);
   assign unused_adr    = ^{wb.wb_adr_i[31:AW+2], wb.wb_adr_i[1:0]};

   assign wb.wb_dat_o = dat_q;
   assign wb.wb_ack_o = ack_q;
   assign wb.wb_err_o = err_q;
   assign wb.wb_rty_o = 1'b0;

   // Linear bursts use an all-ones mask, so the wrap formula degenerates to ptr + 1.
   always_comb begin
      ptr_inc = ptr_q + AW'(1);
      case (bte_q)
         2'b01:   wrap_mask = AW'(3);
         2'b10:   wrap_mask = AW'(7);
         2'b11:   wrap_mask = AW'(15);
         default: wrap_mask = '1;
      endcase
      if (cti_q == 3'b001) begin
         ptr_next = ptr_q;
      end else begin
         ptr_next = (ptr_q & ~wrap_mask) | (ptr_inc & wrap_mask);
      end
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      cti_d   = cti_q;
      bte_d   = bte_q;
      dat_d   = dat_q;
      ack_d   = 1'b0;
      err_d   = 1'b0;
      mem_we  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (req) begin
               if (cti_reserved) begin
                  state_d = S_ERR;
               end else begin
                  ptr_d = wb.wb_adr_i[AW+1:2];
                  cnt_d = 3'(WAIT_STATES);
                  cti_d = wb.wb_cti_i;
                  bte_d = wb.wb_bte_i;
                  if (WAIT_STATES == 0) begin
                     state_d = start_burst ? S_BURST : S_CLASSIC;
                  end else begin
                     state_d = S_WAIT;
                  end
               end
            end
         end
         S_WAIT: begin
            if (!req) begin
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q - 3'd1;
               if (cnt_q == 3'd1) begin
                  state_d = latched_burst ? S_BURST : S_CLASSIC;
               end
            end
         end
         S_CLASSIC: begin
            state_d = S_IDLE;
            if (req) begin
               ack_d  = 1'b1;
               dat_d  = mem[ptr_q];
               mem_we = wb.wb_we_i;
            end
         end
         S_BURST: begin
            if (!req) begin
               state_d = S_IDLE;
            end else if (cti_reserved) begin
               err_d   = 1'b1;
               state_d = S_IDLE;
            end else begin
               ack_d  = 1'b1;
               dat_d  = mem[ptr_q];
               mem_we = wb.wb_we_i;
               ptr_d  = ptr_next;
               if (wb.wb_cti_i == 3'b111) begin
                  state_d = S_IDLE;
               end
            end
         end
         S_ERR: begin
            state_d = S_IDLE;
            err_d   = req;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
      if (!wb_rst_i) begin
         state_q <= S_IDLE;
         ptr_q   <= '0;
         cnt_q   <= '0;
         cti_q   <= '0;
         bte_q   <= '0;
         dat_q   <= '0;
         ack_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
         cti_q   <= cti_d;
         bte_q   <= bte_d;
         dat_q   <= dat_d;
         ack_q   <= ack_d;
         err_q   <= err_d;
      end
   end

   // Memory is not reset; reset holds the FSM in IDLE, which never writes.
   always_ff @(posedge wb_clk_i) begin
      if (mem_we) begin
         for (int b = 0; b < 4; b++) begin
            if (wb.wb_sel_i[b]) begin
               mem[ptr_q][8*b +: 8] <= wb.wb_dat_i[8*b +: 8];
            end
         end
      end
   end
endmodule

// File: tb/tb_wb_burst_ram.sv
// Directed self-checking bench for wb_burst_ram (16-word memory, two wait states).
module tb_wb_burst_ram;
   localparam int MEM_DEPTH   = 16;
   localparam int WAIT_STATES = 2;
   localparam int FIRST_LAT   = 1 + WAIT_STATES;

   logic clk = 1'b0;
   logic rst_n;
   int   checks   = 0;
   int   failures = 0;

   logic [31:0] beat_data [8];
   logic [31:0] beat_rd   [8];

   logic [31:0] rd;
   int          lat;
   int          acked;
   logic        got_ack;
   logic        got_err;
   logic        after_flag;

   wb_burst_ram_if bus ();

   wb_burst_ram #(
      .MEM_DEPTH   (MEM_DEPTH),
      .WAIT_STATES (WAIT_STATES)
   ) dut (
      .wb_clk_i (clk),
      .wb_rst_i (rst_n),
      .wb       (bus)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic req, input logic we, input logic [31:0] adr,
                                input logic [31:0] dat, input logic [3:0] sel,
                                input logic [2:0] cti, input logic [1:0] bte);
      bus.wb_cyc_i = req;
      bus.wb_stb_i = req;
      bus.wb_we_i  = we;
      bus.wb_adr_i = adr;
      bus.wb_dat_i = dat;
      bus.wb_sel_i = sel;
      bus.wb_cti_i = cti;
      bus.wb_bte_i = bte;
   endtask

   task automatic releaseBus();
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 3'b000, 2'b00);
   endtask

   // One non-burst access; lat counts cycles from the edge that first samples req.
   task automatic singleAccess(input logic [31:0] adr, input logic we, input logic [31:0] dat,
                               input logic [3:0] sel, input logic [2:0] cti,
                               output logic [31:0] rdata, output int cycles,
                               output logic ack_seen, output logic err_seen, output logic after);
      applyStimulus(1'b1, we, adr, dat, sel, cti, 2'b00);
      tick();
      cycles = 0;
      while (!bus.wb_ack_o && !bus.wb_err_o && cycles < 20) begin
         tick();
         cycles++;
      end
      rdata    = bus.wb_dat_o;
      ack_seen = bus.wb_ack_o;
      err_seen = bus.wb_err_o;
      releaseBus();
      tick();
      after = bus.wb_ack_o | bus.wb_err_o;
   endtask

   task automatic writeWord(input string tag, input logic [31:0] adr, input logic [31:0] dat,
                            input logic [3:0] sel);
      singleAccess(adr, 1'b1, dat, sel, 3'b000, rd, lat, got_ack, got_err, after_flag);
      checkOutput({tag, "_ack"}, {31'b0, got_ack}, 32'd1);
   endtask

   task automatic readWord(input string tag, input logic [31:0] adr, input logic [31:0] expected);
      singleAccess(adr, 1'b0, 32'h0, 4'hf, 3'b000, rd, lat, got_ack, got_err, after_flag);
      checkOutput(tag, rd, expected);
   endtask

   // Master drives beat k+1 right after seeing the ack of beat k; stop_after drops stb early.
   task automatic runBurst(input string tag, input logic [31:0] adr, input logic we,
                           input logic [2:0] cti, input logic [1:0] bte,
                           input int n, input int stop_after,
                           output int cycles, output int n_acked);
      applyStimulus(1'b1, we, adr, beat_data[0], 4'hf, (n == 1) ? 3'b111 : cti, bte);
      tick();
      cycles = 0;
      while (!bus.wb_ack_o && !bus.wb_err_o && cycles < 20) begin
         tick();
         cycles++;
      end
      n_acked = 0;
      for (int k = 0; k < n; k++) begin
         if (k > 0) tick();
         if (bus.wb_ack_o !== 1'b1) break;
         beat_rd[k] = bus.wb_dat_o;
         n_acked++;
         if (k + 1 == n || k + 1 == stop_after) break;
         bus.wb_dat_i = beat_data[k+1];
         bus.wb_cti_i = (k + 2 == n) ? 3'b111 : cti;
      end
      bus.wb_stb_i = 1'b0;
      tick();
      checkOutput({tag, "_ack_after_end"}, {31'b0, bus.wb_ack_o}, 32'd0);
      releaseBus();
      tick();
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst_n = 1'b0;
      applyStimulus(1'b1, 1'b0, 32'h0, 32'h0, 4'hf, 3'b000, 2'b00);
      repeat (3) tick();
      checkOutput("reset_ack", {31'b0, bus.wb_ack_o}, 32'd0);
      checkOutput("reset_err", {31'b0, bus.wb_err_o}, 32'd0);
      checkOutput("reset_rty", {31'b0, bus.wb_rty_o}, 32'd0);
      checkOutput("reset_dat", bus.wb_dat_o, 32'h0);
      rst_n = 1'b1;
      singleAccess(32'h0, 1'b0, 32'h0, 4'hf, 3'b000, rd, lat, got_ack, got_err, after_flag);
      checkOutput("post_reset_latency", lat, FIRST_LAT);

      // Classic write/partial write/read on word 0x40 (aliases word 0 in a 16-word RAM)
      singleAccess(32'h40, 1'b1, 32'h11223344, 4'hf, 3'b000, rd, lat, got_ack, got_err, after_flag);
      checkOutput("classic_wr_latency", lat, FIRST_LAT);
      checkOutput("classic_wr_after", {31'b0, after_flag}, 32'd0);
      singleAccess(32'h40, 1'b1, 32'hDEADBEEF, 4'b0110, 3'b000, rd, lat, got_ack, got_err, after_flag);
      checkOutput("classic_wr_sel_latency", lat, FIRST_LAT);
      singleAccess(32'h40, 1'b0, 32'h0, 4'hf, 3'b111, rd, lat, got_ack, got_err, after_flag);
      checkOutput("classic_rd_sel_merge", rd, 32'h11ADBE44);

      // Fill words 0..3, then wrap-4 read from word 3
      for (int i = 0; i < 4; i++) beat_data[i] = 32'hC0 + i;
      runBurst("fill", 32'h0, 1'b1, 3'b010, 2'b00, 4, 0, lat, acked);
      checkOutput("fill_beats", acked, 4);
      runBurst("wrap4", 32'h0C, 1'b0, 3'b010, 2'b01, 4, 0, lat, acked);
      checkOutput("wrap4_latency", lat, FIRST_LAT);
      checkOutput("wrap4_beats", acked, 4);
      checkOutput("wrap4_beat0", beat_rd[0], 32'hC3);
      checkOutput("wrap4_beat1", beat_rd[1], 32'hC0);
      checkOutput("wrap4_beat2", beat_rd[2], 32'hC1);
      checkOutput("wrap4_beat3", beat_rd[3], 32'hC2);

      // Linear burst across the top of memory
      for (int i = 0; i < 4; i++) beat_data[i] = 32'hA0 + i;
      runBurst("linear_top", 32'h38, 1'b1, 3'b010, 2'b00, 4, 0, lat, acked);
      checkOutput("linear_top_beats", acked, 4);
      readWord("linear_w14", 32'h38, 32'hA0);
      readWord("linear_w15", 32'h3C, 32'hA1);
      readWord("linear_w0", 32'h00, 32'hA2);
      readWord("linear_w1", 32'h04, 32'hA3);
      readWord("linear_w2_kept", 32'h08, 32'hC2);

      // Constant-address burst
      for (int i = 0; i < 3; i++) beat_data[i] = 32'd1 + i;
      runBurst("const", 32'h20, 1'b1, 3'b001, 2'b00, 3, 0, lat, acked);
      checkOutput("const_beats", acked, 3);
      readWord("const_rd", 32'h20, 32'd3);

      // Reserved cycle type
      singleAccess(32'h20, 1'b1, 32'hFFFFFFFF, 4'hf, 3'b101, rd, lat, got_ack, got_err, after_flag);
      checkOutput("err_latency", lat, 1);
      checkOutput("err_flag", {31'b0, got_err}, 32'd1);
      checkOutput("err_no_ack", {31'b0, got_ack}, 32'd0);
      checkOutput("err_one_cycle", {31'b0, after_flag}, 32'd0);
      readWord("err_mem_kept", 32'h20, 32'd3);

      // 8-beat burst aborted after beat 2
      for (int i = 0; i < 8; i++) beat_data[i] = 32'hB0 + i;
      runBurst("abort", 32'h0, 1'b1, 3'b010, 2'b00, 8, 2, lat, acked);
      checkOutput("abort_beats", acked, 2);
      readWord("abort_w0", 32'h00, 32'hB0);
      readWord("abort_w1", 32'h04, 32'hB1);
      readWord("abort_w2_kept", 32'h08, 32'hC2);
      readWord("abort_w3_kept", 32'h0C, 32'hC3);

      // Asynchronous reset in the middle of a write burst starting at word 7
      applyStimulus(1'b1, 1'b1, 32'h1C, 32'hE0, 4'hf, 3'b010, 2'b00);
      tick();
      lat = 0;
      while (!bus.wb_ack_o && lat < 20) begin
         tick();
         lat++;
      end
      checkOutput("rst_burst_first_ack", {31'b0, bus.wb_ack_o}, 32'd1);
      bus.wb_dat_i = 32'hE1;
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("rst_async_ack", {31'b0, bus.wb_ack_o}, 32'd0);
      checkOutput("rst_async_dat", bus.wb_dat_o, 32'h0);
      tick();
      releaseBus();
      rst_n = 1'b1;
      tick();
      readWord("rst_w7_written", 32'h1C, 32'hE0);
      readWord("rst_w8_kept", 32'h20, 32'd3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
